// File: rtl/eu_iqueue_mq_if.sv
//------------------------------------------------------------------------------
// eu_iqueue_mq_if
//   Dispatch/issue bus of the multi-bank execution-unit instruction queue,
//   together with the shared data-type package it depends on.
//
//   pkg_dtypes        : LOG2_NUM_EXEC_UNITS and the queue entry payload type.
//   eu_iqueue_mq_if   : dispatch side   dispatched_instr_i / _valid_i /
//                                       _alloc_euidx_i (per lane), is_full_o
//                       issue side      curr_instr_to_exec_o / _valid_o,
//                                       ready_for_next_instr_i
//   modport slave  : the queue itself.
//   modport master : the dispatcher/EU environment driving the queue.
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pkg_dtypes;
  localparam int LOG2_NUM_EXEC_UNITS = 2;
  typedef logic [31:0] type_iqueue_entry;
endpackage

interface eu_iqueue_mq_if #(
  parameter int NUM_PARALLEL_INSTR_DISPATCHES = 4
);
  import pkg_dtypes::*;

  type_iqueue_entry [NUM_PARALLEL_INSTR_DISPATCHES-1:0]                          dispatched_instr_i;
  logic             [NUM_PARALLEL_INSTR_DISPATCHES-1:0]                          dispatched_instr_valid_i;
  logic             [NUM_PARALLEL_INSTR_DISPATCHES-1:0][LOG2_NUM_EXEC_UNITS-1:0] dispatched_instr_alloc_euidx_i;
  logic                                                                          is_full_o;
  type_iqueue_entry                                                              curr_instr_to_exec_o;
  logic                                                                          curr_instr_to_exec_valid_o;
  logic                                                                          ready_for_next_instr_i;

  modport slave (
    input  dispatched_instr_i,
    input  dispatched_instr_valid_i,
    input  dispatched_instr_alloc_euidx_i,
    output is_full_o,
    output curr_instr_to_exec_o,
    output curr_instr_to_exec_valid_o,
    input  ready_for_next_instr_i
  );

  modport master (
    output dispatched_instr_i,
    output dispatched_instr_valid_i,
    output dispatched_instr_alloc_euidx_i,
    input  is_full_o,
    input  curr_instr_to_exec_o,
    input  curr_instr_to_exec_valid_o,
    output ready_for_next_instr_i
  );
endinterface

`default_nettype wire

// File: rtl/eu_iqueue_mq.sv
//------------------------------------------------------------------------------
// eu_iqueue_mq
//   Multi-bank instruction queue for one execution unit. Dispatch lanes that
//   target EU_IDX are compacted and written round-robin into NUM_QUEUES FIFO
//   banks starting at wr_ptr; the EU reads round-robin from rd_ptr, so global
//   dispatch order is preserved. A dispatch is accepted all-or-nothing.
//
//   Ports
//     clk      : clock
//     reset    : synchronous active-high reset (same effect as flush_i)
//     flush_i  : drop all queued entries and any same-cycle dispatch
//     iq       : eu_iqueue_mq_if.slave dispatch/issue bus
//     occupancy_o (only with EU_IQUEUE_OCCUPANCY_EN) : registered entry count
//
//   Optional feature macro: EU_IQUEUE_OCCUPANCY_EN
//
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module eu_iqueue_mq
  import pkg_dtypes::*;
#(
  parameter int                             LOG2_QUEUE_LENGTH             = 2,
  parameter int                             EU_LOG2_IQUEUE_NUM_QUEUES     = 2,
  parameter int                             NUM_PARALLEL_INSTR_DISPATCHES = 4,
  parameter logic [LOG2_NUM_EXEC_UNITS-1:0] EU_IDX                        = '0
) (
  input  wire logic           clk,
  input  wire logic           reset,
  input  wire logic           flush_i,
  eu_iqueue_mq_if.slave       iq
`ifdef EU_IQUEUE_OCCUPANCY_EN
  ,
  output logic [EU_LOG2_IQUEUE_NUM_QUEUES+LOG2_QUEUE_LENGTH:0] occupancy_o
`endif
);

  localparam int NQ  = 1 << EU_LOG2_IQUEUE_NUM_QUEUES;
  localparam int QL  = 1 << LOG2_QUEUE_LENGTH;
  localparam int NPD = NUM_PARALLEL_INSTR_DISPATCHES;
  localparam int PW  = EU_LOG2_IQUEUE_NUM_QUEUES;
  localparam int HW  = LOG2_QUEUE_LENGTH;
  localparam int CW  = LOG2_QUEUE_LENGTH + 1;

  // Each lane must land in a distinct bank within one cycle.
  if (NUM_PARALLEL_INSTR_DISPATCHES > NQ) begin : g_bad_cfg
    $error("eu_iqueue_mq: NUM_PARALLEL_INSTR_DISPATCHES must be <= NUM_QUEUES");
  end

  // State
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [HW-1:0]    head_q [NQ];
  logic [HW-1:0]    head_d [NQ];
  logic [HW-1:0]    tail_q [NQ];
  logic [HW-1:0]    tail_d [NQ];
  logic [CW-1:0]    cnt_q  [NQ];
  logic [CW-1:0]    cnt_d  [NQ];
  type_iqueue_entry mem_q  [NQ][QL];

  // Combinational
  type_iqueue_entry slot      [NPD];
  int               n_rel;
  logic             bank_hit;
  logic             kill;
  logic             accept;
  logic             push      [NQ];
  type_iqueue_entry push_data [NQ];
  logic             head_valid;
  logic             pop;

  // Compaction: the n-th relevant lane (ascending lane order) goes to slot n.
  always_comb begin
    n_rel = 0;
    for (int j = 0; j < NPD; j++) slot[j] = '0;
    for (int i = 0; i < NPD; i++) begin
      if (iq.dispatched_instr_valid_i[i] && (iq.dispatched_instr_alloc_euidx_i[i] == EU_IDX)) begin
        for (int j = 0; j < NPD; j++) begin
          if (j == n_rel) slot[j] = iq.dispatched_instr_i[i];
        end
        n_rel = n_rel + 1;
      end
    end
  end

  // Acceptance looks only at current-cycle counts: a same-cycle pop does not
  // make room for the dispatch.
  always_comb begin
    bank_hit = 1'b0;
    for (int j = 0; j < NPD; j++) begin
      if ((j < n_rel) && (cnt_q[wr_ptr_q + PW'(j)] == CW'(QL))) bank_hit = 1'b1;
    end
    kill         = reset | flush_i;
    accept       = (n_rel != 0) && !bank_hit && !kill;
    iq.is_full_o = (n_rel != 0) &&  bank_hit && !kill;
  end

  always_comb begin
    for (int b = 0; b < NQ; b++) begin
      push[b]      = 1'b0;
      push_data[b] = '0;
    end
    for (int j = 0; j < NPD; j++) begin
      if (accept && (j < n_rel)) begin
        push[wr_ptr_q + PW'(j)]      = 1'b1;
        push_data[wr_ptr_q + PW'(j)] = slot[j];
      end
    end
  end

  // Issue straight from storage of the bank under rd_ptr.
  always_comb begin
    head_valid                    = (cnt_q[rd_ptr_q] != '0);
    pop                           = iq.ready_for_next_instr_i && head_valid;
    iq.curr_instr_to_exec_valid_o = head_valid;
    iq.curr_instr_to_exec_o       = head_valid ? mem_q[rd_ptr_q][head_q[rd_ptr_q]] : '0;
  end

  always_comb begin
    logic pop_b;
    pop_b = 1'b0;
    for (int b = 0; b < NQ; b++) begin
      pop_b     = pop && (rd_ptr_q == PW'(b));
      head_d[b] = head_q[b] + HW'(pop_b);
      tail_d[b] = tail_q[b] + HW'(push[b]);
      cnt_d[b]  = cnt_q[b] + CW'(push[b]) - CW'(pop_b);
    end
    wr_ptr_d = accept ? (wr_ptr_q + PW'(n_rel)) : wr_ptr_q;
    rd_ptr_d = rd_ptr_q + PW'(pop);
    if (flush_i) begin
      for (int b = 0; b < NQ; b++) begin
        head_d[b] = '0;
        tail_d[b] = '0;
        cnt_d[b]  = '0;
      end
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int b = 0; b < NQ; b++) begin
        head_q[b] <= '0;
        tail_q[b] <= '0;
        cnt_q[b]  <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int b = 0; b < NQ; b++) begin
        head_q[b] <= head_d[b];
        tail_q[b] <= tail_d[b];
        cnt_q[b]  <= cnt_d[b];
      end
    end
  end

  // Storage is not reset; push is already suppressed under reset/flush.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NQ; b++) begin
      if (push[b]) mem_q[b][tail_q[b]] <= push_data[b];
    end
  end

`ifdef EU_IQUEUE_OCCUPANCY_EN
  localparam int OW = EU_LOG2_IQUEUE_NUM_QUEUES + LOG2_QUEUE_LENGTH + 1;
  logic [OW-1:0] occ_q, occ_d;

  always_comb begin
    occ_d = occ_q + (accept ? OW'(n_rel) : '0) - OW'(pop);
    if (flush_i) occ_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) occ_q <= '0;
    else       occ_q <= occ_d;
  end

  assign occupancy_o = occ_q;
`endif

endmodule

`default_nettype wire
